subadc_collector: RTL
=====================

Name: subadc_collector

Overview:
- Sits directly downstream of the N sub-ADCs in the time-interleaved ADC model.
- Synchronises each lane's `subadc_compl` into the system clock and captures the lane's `subadc_data` on the completion edge.
- Re-orders the captured words into strict interleave order (lane 0,1,…,N_WAYS-1,0,…).
- Streams the words out through a valid/ready FIFO and flags lost conversions.

Parameters:
- ADC_BITS, 8: bits per sub-ADC word.
- N_WAYS, 4: number of interleaved sub-ADC lanes (≥2).
- FIFO_DEPTH, 8: output FIFO entries (power of 2, ≥2).

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  capture enable.
- subadc_data  input  N_WAYS*ADC_BITS  lane k occupies bits [k*ADC_BITS +: ADC_BITS]; MSB-first word as produced by each sub-ADC.
- subadc_compl  input  N_WAYS  per-lane conversion-complete level; asynchronous to clk.
- out_data  output  ADC_BITS  head-of-FIFO sample.
- out_lane  output  LANE_W  lane index of out_data.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts when out_valid&out_ready.
- overrun  output  1  sticky lost-sample flag.
- lost_cnt  output  16  count of dropped conversions.

Behaviour:
- **Reset.** rst is synchronous and active-high; clk is the only clock. On rst:
  - out_valid=0, out_data=0, out_lane=0, overrun=0, lost_cnt=0.
  - FIFO emptied, all hold_full=0, exp_lane=0.
  - Synchroniser flops s1/s2/s3 set to 1, so a lane already high at reset needs a fresh rising edge.
  - A reset mid-operation discards all held and queued samples.
- **Synchroniser.** Per lane, s1<=compl, s2<=s1, s3<=s2. rise_k = s2 & ~s3.
- **Capture.** At the edge where rise_k=1 and en=1:
  - if hold_full[k]=0: hold[k]<=lane data, hold_full[k]<=1.
  - else: drop the new word, set overrun<=1, lost_cnt saturating +1 (stays 16'hFFFF).
- **Capture window.** Upstream guarantees data is stable while compl is high. Data is sampled directly, not synchronised.
- **Multiple lanes.** Simultaneous rises on several lanes are all captured in the same cycle. Each lost one adds 1; lost_cnt adds the popcount of the drops.
- **en low.** Rises are ignored and not counted. Held words and the FIFO continue draining.
- **Reorder.** If hold_full[exp_lane]=1 and the FIFO can accept:
  - push {exp_lane, hold[exp_lane]};
  - clear hold_full[exp_lane];
  - exp_lane wraps N_WAYS-1 → 0.
  - At most one push per cycle.
  - A capture and a clear on the same lane in the same cycle: the capture wins (hold reloaded, full stays 1).
- **FIFO accept rule.** The FIFO accepts when count<FIFO_DEPTH, or when count==FIFO_DEPTH and a pop occurs in the same cycle.
- **FIFO output.** out_valid = count≠0. Pop on out_valid&out_ready.
  - out_data/out_lane show the head entry.
  - They must stay stable while out_valid&~out_ready.
  - Empty: out_valid=0; out_data and out_lane hold their last value.
- **Latency.** compl first sampled high at edge E0 → rise during E1–E2 → hold loaded at E2 → pushed at E3 → out_valid=1 after E3. This is 3 cycles with an empty FIFO and the lane equal to exp_lane.
- **Out-of-order lanes.** A lane completing before exp_lane waits in its hold register. Only one word per lane can wait; a second completion of that lane is an overrun.

Decomposition:
- Shared package adc_model_pkg:
  - function/constant LANE_W = (N_WAYS>1) ? $clog2(N_WAYS) : 1;
  - typedef struct packed {lane, data} for the FIFO entry, parameterised via localparams in the module;
  - LOST_CNT_W=16.
- One sub-module, sync_fifo: generic width/depth, synchronous-reset FIFO with push/pop/count/full/empty, same-cycle push+pop at full permitted.
- Synchronisers and reorder stay inline.

Test Plan:
1. rst, en=1; lanes 0..3 complete in order with data 8'h10,8'h21,8'h32,8'h43 spaced 6 cycles → out stream (lane,data) = (0,10),(1,21),(2,32),(3,43); first out_valid exactly 3 cycles after compl[0] sampled high; overrun=0.
2. Lanes complete 3,2,1,0 simultaneously-staggered (lane 3 first) with data A3,A2,A1,A0 → output still lane order 0,1,2,3; out_valid first rises 1 cycle after lane 0 captured.
3. Lane 1 completes twice (8'h55 then 8'h66) while lane 0 has not completed; then lane 0 completes with 8'h44 → outputs (0,44),(1,55); 8'h66 dropped; overrun=1, lost_cnt=1.
4. out_ready=0, stream 12 in-order samples → exactly FIFO_DEPTH=8 entries queued plus holds full, further completions counted in lost_cnt; release out_ready → entries drained in order with no duplication.
5. compl[0] held high through rst release → no capture until compl falls and rises again; en=0 during a completion → nothing captured, lost_cnt unchanged.
6. Force lost_cnt to 16'hFFFE via repeated overruns, add 3 more → lost_cnt stays 16'hFFFF; rst mid-stream (FIFO holding 5) → next cycle out_valid=0, counters 0, exp_lane=0.

Source files
------------

// File: rtl/adc_model_pkg.sv
// rtl/adc_model_pkg.sv - shared constants and helpers for the interleaved ADC model
package adc_model_pkg;

  localparam int LOST_CNT_W = 16;

  function automatic int lane_w(input int n_ways);
    return (n_ways > 1) ? $clog2(n_ways) : 1;
  endfunction

endpackage

// File: rtl/subadc_collector_sync_fifo.sv
// rtl/subadc_collector_sync_fifo.sv - generic synchronous FIFO, push at full allowed with a same-cycle pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/subadc_collector.sv
// rtl/subadc_collector.sv - syncs sub-ADC completions, captures words, reorders into lane order and queues them
module subadc_collector
  import adc_model_pkg::*;
#(
  parameter int ADC_BITS   = 8,
  parameter int N_WAYS     = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int LANE_W    = lane_w(N_WAYS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [N_WAYS*ADC_BITS-1:0]   subadc_data,
  input  logic [N_WAYS-1:0]            subadc_compl,
  output logic [ADC_BITS-1:0]          out_data,
  output logic [LANE_W-1:0]            out_lane,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         overrun,
  output logic [LOST_CNT_W-1:0]        lost_cnt
);

  typedef struct packed {
    logic [LANE_W-1:0]   lane;
    logic [ADC_BITS-1:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [N_WAYS-1:0]     s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [N_WAYS-1:0]     hold_full_q, hold_full_d;
  logic [ADC_BITS-1:0]   hold_q [N_WAYS];
  logic [ADC_BITS-1:0]   hold_d [N_WAYS];
  logic [LANE_W-1:0]     exp_lane_q, exp_lane_d;
  logic [LOST_CNT_W-1:0] lost_cnt_q, lost_cnt_d;
  logic                  overrun_q, overrun_d;
  entry_t                last_q, last_d;

  logic [N_WAYS-1:0]     cap, clr, load, drop;
  logic [LOST_CNT_W:0]   lost_sum;
  logic                  push, pop;
  entry_t                push_entry, head;
  logic                  fifo_full, fifo_empty;
  logic [PTR_W:0]        fifo_count;

  assign s1_d = subadc_compl;
  assign s2_d = s1_q;
  assign s3_d = s2_q;
  assign cap  = s2_q & ~s3_q & {N_WAYS{en}};

  assign pop  = out_valid & out_ready;
  assign push = hold_full_q[exp_lane_q] & (~fifo_full | pop);

  // A word leaving its hold register this cycle frees the slot for a same-cycle capture.
  always_comb begin
    clr = '0;
    if (push) clr[exp_lane_q] = 1'b1;
  end

  assign load = cap & (~hold_full_q | clr);
  assign drop = cap & hold_full_q & ~clr;

  always_comb begin
    hold_full_d = (hold_full_q & ~clr) | load;
    for (int k = 0; k < N_WAYS; k++) begin
      hold_d[k] = load[k] ? subadc_data[k*ADC_BITS +: ADC_BITS] : hold_q[k];
    end
    push_entry.lane = exp_lane_q;
    push_entry.data = hold_q[exp_lane_q];
    exp_lane_d = exp_lane_q;
    if (push) begin
      exp_lane_d = (exp_lane_q == LANE_W'(N_WAYS-1)) ? '0 : exp_lane_q + LANE_W'(1);
    end
  end

  always_comb begin
    lost_sum = {1'b0, lost_cnt_q};
    for (int k = 0; k < N_WAYS; k++) begin
      lost_sum = lost_sum + {{LOST_CNT_W{1'b0}}, drop[k]};
    end
    lost_cnt_d = lost_sum[LOST_CNT_W] ? '1 : lost_sum[LOST_CNT_W-1:0];
    overrun_d  = overrun_q | (|drop);
  end

  // The last popped entry keeps the outputs steady while the FIFO is empty.
  assign last_d    = pop ? head : last_q;
  assign out_valid = (fifo_count != '0);
  assign out_data  = fifo_empty ? last_q.data : head.data;
  assign out_lane  = fifo_empty ? last_q.lane : head.lane;
  assign overrun   = overrun_q;
  assign lost_cnt  = lost_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '1;
      s2_q        <= '1;
      s3_q        <= '1;
      hold_full_q <= '0;
      exp_lane_q  <= '0;
      lost_cnt_q  <= '0;
      overrun_q   <= 1'b0;
      last_q      <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      hold_full_q <= hold_full_d;
      exp_lane_q  <= exp_lane_d;
      lost_cnt_q  <= lost_cnt_d;
      overrun_q   <= overrun_d;
      last_q      <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
